des_round_engine: RTL and testbench
===================================

# des_round_engine

Iterative DES datapath that takes one 64-bit block and the sixteen 48-bit round subkeys, and produces the 64-bit result. It applies IP, runs the sixteen Feistel rounds at one round per clock, swaps the halves, and applies FP. It sits directly downstream of the combinational subkey generator: the generator's `subkey0`…`subkey15` outputs wire straight into this block's subkey ports. A start/busy/done handshake lets a top-level controller launch a block and collect the result.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low; sampled on `clk` rising edge.
- `start`  in  1  request to process `data_in`; accepted only in IDLE.
- `decrypt`  in  1  0 = encrypt (K1→K16), 1 = decrypt (K16→K1); sampled with `start`.
- `data_in`  in  64  input block; `data_in[63]` = DES bit 1 (MSB-first, standard hex vectors).
- `subkey0` … `subkey15`  in  48 each  round keys K1…K16; `subkeyN[47]` = bit 1 of K(N+1).
- `data_out`  out  64  result block, same bit order as `data_in`; holds until next completion.
- `busy`  out  1  high while a block is in flight.
- `done`  out  1  one-cycle pulse when `data_out` is updated.

## Operation
- FSM states: IDLE, ROUND, FINISH.
- IDLE → ROUND:
  - Trigger: `start`=1.
  - Register `{L,R}` = IP(`data_in`).
  - Latch `decrypt` into `mode_q`.
  - `rnd` = 0; `busy` = 1.
- ROUND: each cycle computes `L` ← `R` and `R` ← `L` ^ f(`R`, K).
  - K = `subkey[rnd]` when `mode_q`=0, `subkey[15-rnd]` when `mode_q`=1.
  - f = E-expansion (32→48), XOR with K, S1–S8 (6→4 each), P (32→32).
  - `rnd` is a 4-bit counter and increments each cycle. When `rnd`=15, the round still executes and the FSM goes to FINISH.
- FINISH:
  - `data_out` ← FP({`R`,`L`}), i.e. the final halves swapped.
  - `done` = 1 for this cycle only; `busy` = 0.
  - Return to IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- `data_in` is used only on the accepting edge.
- Subkey ports must stay stable from `start` acceptance until `done`. The block does not register them.
- S-boxes are combinational ROMs inside the block: eight 64×4 lookups, row = bits {1,6}, column = bits {2..5}.
- The internal `{L,R}` registers are not visible at the outputs.

## Timing
- Reset (`rst`=0 at a rising edge) forces:
  - FSM to IDLE, `rnd`=0, `mode_q`=0.
  - `L`=`R`=0, `data_out`=64'h0, `busy`=0, `done`=0.
  - This applies from any state. Reset mid-ROUND abandons the block and no `done` is produced.
- Latency, with `start` sampled at edge 0:
  - `busy`=1 after edge 0.
  - Rounds 1–16 execute on edges 1–16.
  - After edge 17, `data_out` is valid and `done`=1.
  - After edge 18, `done`=0.
- Back-to-back blocks: `start` held high or re-asserted in the cycle where `done`=1 is accepted at edge 18 (FSM is IDLE then). Minimum issue interval is 18 cycles.
- `busy` and `done` are never high in the same cycle.

## Configuration
- Macro: `DES_ROUND_ENGINE_DECRYPT_EN`.
- Defined:
  - `decrypt` port is functional.
  - Reversed subkey selection mux is present.
- Undefined:
  - `decrypt` port exists but is ignored.
  - `mode_q` is tied to 0 and the engine always encrypts.
  - The 16:1 index mux uses `rnd` directly.

## Test plan
- Standard vector, encrypt: key 133457799BBCDFF1 subkeys driven directly (K1=1B02EFFC7072 … K16=CB3D8B0E17F5), `data_in`=0123456789ABCDEF, `decrypt`=0 → `done` after edge 17, `data_out`=85E813540F0AB405.
- Decrypt (macro defined): same subkeys, `data_in`=85E813540F0AB405, `decrypt`=1 → `data_out`=0123456789ABCDEF. Same stimulus with macro undefined → `data_out` equals the encryption of 85E813540F0AB405.
- Zero vector: all-zero key subkeys (all zero), `data_in`=0 → `data_out`=8CA64DE9C1B123A7.
- Handshake: pulse `start` again at edges 5 and 16 with a different `data_in` → ignored, single `done`, result unchanged. Then hold `start` through `done` → second block accepted at edge 18, second `done` after edge 35.
- Reset mid-operation: `rst`=0 at edge 8 → `busy`=0, `data_out`=0, no `done`. A fresh `start` afterwards yields the correct 85E813540F0AB405 after 17 edges.
- Reset values: hold `rst`=0 for 3 cycles with `start`=1 → `busy`=`done`=0, `data_out`=0 throughout.

Source files
------------

// File: rtl/des_round_engine.sv
// des_round_engine
//   Iterative DES datapath: IP, sixteen Feistel rounds at one round per clock,
//   half swap and FP. One 64-bit block in flight at a time.
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   rst                 synchronous active-low reset
//   start               launch a block; accepted only while idle
//   decrypt             0 = encrypt (K1..K16), 1 = decrypt (K16..K1), sampled with start
//   data_in[63:0]       input block, data_in[63] = DES bit 1
//   subkey0..subkey15   round keys K1..K16 (48 bits each, [47] = key bit 1),
//                       must stay stable from start acceptance until done
//   data_out[63:0]      result block, held until the next completion
//   busy                high while a block is in flight
//   done                one-cycle pulse when data_out is updated
//
// Configuration
//   DES_ROUND_ENGINE_DECRYPT_EN  defined: decrypt is functional (reversed key order).
//                                undefined: decrypt is ignored, the engine always encrypts.

module des_round_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] data_in,
  input  logic [47:0] subkey0,
  input  logic [47:0] subkey1,
  input  logic [47:0] subkey2,
  input  logic [47:0] subkey3,
  input  logic [47:0] subkey4,
  input  logic [47:0] subkey5,
  input  logic [47:0] subkey6,
  input  logic [47:0] subkey7,
  input  logic [47:0] subkey8,
  input  logic [47:0] subkey9,
  input  logic [47:0] subkey10,
  input  logic [47:0] subkey11,
  input  logic [47:0] subkey12,
  input  logic [47:0] subkey13,
  input  logic [47:0] subkey14,
  input  logic [47:0] subkey15,
  output logic [63:0] data_out,
  output logic        busy,
  output logic        done
);

  // Permutation tables hold 1-based DES source bit numbers, entry 0 in the MSBs.
  localparam logic [511:0] IP_TAB = {
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
    8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
    8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
    8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
    8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7
  };

  localparam logic [511:0] FP_TAB = {
    8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,
    8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
    8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,
    8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
    8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,
    8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
    8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,
    8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25
  };

  localparam logic [383:0] E_TAB = {
    8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,
    8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
    8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13,
    8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
    8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21,
    8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
    8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29,
    8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1
  };

  localparam logic [255:0] P_TAB = {
    8'd16, 8'd7,  8'd20, 8'd21,
    8'd29, 8'd12, 8'd28, 8'd17,
    8'd1,  8'd15, 8'd23, 8'd26,
    8'd5,  8'd18, 8'd31, 8'd10,
    8'd2,  8'd8,  8'd24, 8'd14,
    8'd32, 8'd27, 8'd3,  8'd9,
    8'd19, 8'd13, 8'd30, 8'd6,
    8'd22, 8'd11, 8'd4,  8'd25
  };

  // S1..S8, each as four rows of sixteen nibbles; entry (box, row, col) sits
  // at flat nibble index box*64 + row*16 + col counted from the MSB end.
  localparam logic [2047:0] SBOX = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    int          t;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      t         = int'(IP_TAB[(63 - i) * 8 +: 8]);
      y[63 - i] = x[64 - t];
    end
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    int          t;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      t         = int'(FP_TAB[(63 - i) * 8 +: 8]);
      y[63 - i] = x[64 - t];
    end
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    int          t;
    y = '0;
    for (int i = 0; i < 48; i++) begin
      t         = int'(E_TAB[(47 - i) * 8 +: 8]);
      y[47 - i] = x[32 - t];
    end
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    int          t;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      t         = int'(P_TAB[(31 - i) * 8 +: 8]);
      y[31 - i] = x[32 - t];
    end
    return y;
  endfunction

  // Row comes from the outer bits {1,6} of each 6-bit group, column from bits 2..5.
  function automatic logic [31:0] sbox_layer(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b6;
    int          idx;
    y = '0;
    for (int b = 0; b < 8; b++) begin
      b6  = x[(7 - b) * 6 +: 6];
      idx = b * 64 + int'({b6[5], b6[0]}) * 16 + int'(b6[4:1]);
      y[(7 - b) * 4 +: 4] = SBOX[(511 - idx) * 4 +: 4];
    end
    return y;
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, FINISH} state_t;

  state_t      state;
  logic [3:0]  rnd;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [3:0]  key_idx;
  logic [47:0] round_key;
  logic [31:0] f_out;

`ifdef DES_ROUND_ENGINE_DECRYPT_EN
  logic mode_q;

  // Decrypt walks the same key schedule backwards.
  assign key_idx = mode_q ? (4'd15 - rnd) : rnd;
`else
  // Encrypt-only build: the decrypt pin is kept for port compatibility.
  logic unused_decrypt;

  assign unused_decrypt = decrypt;
  assign key_idx        = rnd;
`endif

  always_comb begin
    round_key = subkey0;
    case (key_idx)
      4'd0:    round_key = subkey0;
      4'd1:    round_key = subkey1;
      4'd2:    round_key = subkey2;
      4'd3:    round_key = subkey3;
      4'd4:    round_key = subkey4;
      4'd5:    round_key = subkey5;
      4'd6:    round_key = subkey6;
      4'd7:    round_key = subkey7;
      4'd8:    round_key = subkey8;
      4'd9:    round_key = subkey9;
      4'd10:   round_key = subkey10;
      4'd11:   round_key = subkey11;
      4'd12:   round_key = subkey12;
      4'd13:   round_key = subkey13;
      4'd14:   round_key = subkey14;
      default: round_key = subkey15;
    endcase
  end

  // Feistel function f(R, K)
  assign f_out = p_perm(sbox_layer(e_expand(r_q) ^ round_key));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rnd      <= 4'd0;
      l_q      <= 32'h0;
      r_q      <= 32'h0;
      data_out <= 64'h0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef DES_ROUND_ENGINE_DECRYPT_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            {l_q, r_q} <= ip_perm(data_in);
            rnd        <= 4'd0;
            busy       <= 1'b1;
            state      <= ROUND;
`ifdef DES_ROUND_ENGINE_DECRYPT_EN
            mode_q     <= decrypt;
`endif
          end
        end
        ROUND: begin
          l_q <= r_q;
          r_q <= l_q ^ f_out;
          rnd <= rnd + 4'd1;
          if (rnd == 4'd15) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          // Halves are swapped before the final permutation.
          data_out <= fp_perm({r_q, l_q});
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine
//   Directed-vector bench for des_round_engine: standard DES key schedule of
//   key 133457799BBCDFF1, all-zero key, handshake behaviour and resets.

module tb_des_round_engine;

  localparam logic [63:0] P0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C0 = 64'h85E813540F0AB405;
  localparam logic [63:0] ZC = 64'h8CA64DE9C1B123A7;

  logic        clk;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [63:0] data_in;
  logic [47:0] sk [16];
  logic [63:0] data_out;
  logic        busy;
  logic        done;

  int tests_run;
  int tests_failed;

  des_round_engine dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .decrypt  (decrypt),
    .data_in  (data_in),
    .subkey0  (sk[0]),
    .subkey1  (sk[1]),
    .subkey2  (sk[2]),
    .subkey3  (sk[3]),
    .subkey4  (sk[4]),
    .subkey5  (sk[5]),
    .subkey6  (sk[6]),
    .subkey7  (sk[7]),
    .subkey8  (sk[8]),
    .subkey9  (sk[9]),
    .subkey10 (sk[10]),
    .subkey11 (sk[11]),
    .subkey12 (sk[12]),
    .subkey13 (sk[13]),
    .subkey14 (sk[14]),
    .subkey15 (sk[15]),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_std_keys();
    sk[0]  = 48'h1B02EFFC7072;  sk[1]  = 48'h79AED9DBC9E5;
    sk[2]  = 48'h55FC8A42CF99;  sk[3]  = 48'h72ADD6DB351D;
    sk[4]  = 48'h7CEC07EB53A8;  sk[5]  = 48'h63A53E507B2F;
    sk[6]  = 48'hEC84B7F618BC;  sk[7]  = 48'hF78A3AC13BFB;
    sk[8]  = 48'hE0DBEBEDE781;  sk[9]  = 48'hB1F347BA464F;
    sk[10] = 48'h215FD3DED386;  sk[11] = 48'h7571F59467E9;
    sk[12] = 48'h97C5D1FABA41;  sk[13] = 48'h5F43B7F2E73A;
    sk[14] = 48'hBF918D3D3F0A;  sk[15] = 48'hCB3D8B0E17F5;
  endtask

  // Launch one block at edge 0, wait (bounded) for done, check latency and result.
  task automatic run_block(input logic [63:0] din, input logic dec,
                           input logic [63:0] exp, input string tag);
    int lat;
    data_in = din;
    decrypt = dec;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    data_in = ~din;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    for (int e = 1; e <= 40 && lat == 0; e++) begin
      tick();
      check_eq({tag, "_excl"}, 64'(busy & done), 64'd0);
      if (done) lat = e;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'd17);
    check_eq({tag, "_out"}, data_out, exp);
    tick();
    check_eq({tag, "_done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dones;
    int first_done;
    int second_done;
    int busy18;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    start        = 1'b1;
    decrypt      = 1'b0;
    data_in      = P0;
    load_std_keys();

    // Reset held three cycles with start asserted.
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_out", data_out, 64'h0);
    end
    start = 1'b0;
    rst   = 1'b1;
    tick();

    run_block(P0, 1'b0, C0, "enc_std");

`ifdef DES_ROUND_ENGINE_DECRYPT_EN
    run_block(C0, 1'b1, P0, "dec_std");
`else
    run_block(P0, 1'b1, C0, "dec_ignored");
`endif

    for (int i = 0; i < 16; i++) sk[i] = 48'h0;
    run_block(64'h0, 1'b0, ZC, "zero_vec");
    load_std_keys();

    // Start pulses during ROUND (edges 5 and 16) must be ignored.
    data_in = P0;
    decrypt = 1'b0;
    start   = 1'b1;
    tick();
    start      = 1'b0;
    dones      = 0;
    first_done = 0;
    for (int e = 1; e <= 22; e++) begin
      if (e == 5 || e == 16) begin
        data_in = 64'hFFFF0000FFFF0000;
        start   = 1'b1;
      end else begin
        start   = 1'b0;
      end
      tick();
      if (done) begin
        dones++;
        if (first_done == 0) first_done = e;
      end
    end
    check_eq("hs_ign_dones", 64'(dones), 64'd1);
    check_eq("hs_ign_edge", 64'(first_done), 64'd17);
    check_eq("hs_ign_out", data_out, C0);
    check_eq("hs_ign_idle", 64'(busy), 64'd0);

    // start held through done: second block accepted at edge 18.
    data_in     = P0;
    start       = 1'b1;
    tick();
    dones       = 0;
    first_done  = 0;
    second_done = 0;
    busy18      = 0;
    for (int e = 1; e <= 40; e++) begin
      if (e == 19) start = 1'b0;
      tick();
      if (e == 18) busy18 = int'(busy);
      if (done) begin
        dones++;
        if (first_done == 0) first_done = e;
        else if (second_done == 0) second_done = e;
      end
    end
    check_eq("b2b_dones", 64'(dones), 64'd2);
    check_eq("b2b_first", 64'(first_done), 64'd17);
    check_eq("b2b_second", 64'(second_done), 64'd35);
    check_eq("b2b_busy18", 64'(busy18), 64'd1);
    check_eq("b2b_out", data_out, C0);

    // Reset at edge 8 abandons the block.
    data_in = P0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      if (e == 8) rst = 1'b0;
      tick();
    end
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_done", 64'(done), 64'd0);
    check_eq("mid_rst_out", data_out, 64'h0);
    rst   = 1'b1;
    dones = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (done) dones++;
    end
    check_eq("mid_rst_no_done", 64'(dones), 64'd0);
    check_eq("mid_rst_idle", 64'(busy), 64'd0);

    run_block(P0, 1'b0, C0, "rst_fresh");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
